// File: rtl/wam_pkg.sv
// Shared whack-a-mole definitions: counter and index widths, LFSR constants
// and the mole scheduler state encoding.
package wam_pkg;

  localparam int CNT_W  = 27;
  localparam int IDX_W  = 4;
  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mole_scheduler_if.sv
// Round configuration, button and mole status signals between the game
// control / IO side (master) and the mole scheduler (slave).
interface mole_scheduler_if #(
  parameter int CNT_W = wam_pkg::CNT_W,
  parameter int IDX_W = wam_pkg::IDX_W
) ();

  logic             cfg_load;
  logic [CNT_W-1:0] cfg_interval;
  logic [CNT_W-1:0] cfg_duration;
  logic [2:0]       cfg_molenum;
  logic             hit;
  logic [IDX_W-1:0] hit_index;

  logic             mole_appear;
  logic [IDX_W-1:0] mole_index;
  logic             hit_success;
  logic             miss;
  logic [2:0]       hit_count;
  logic             round_busy;
  logic             round_done;

  modport master (
    output cfg_load, cfg_interval, cfg_duration, cfg_molenum, hit, hit_index,
    input  mole_appear, mole_index, hit_success, miss, hit_count,
           round_busy, round_done
  );

  modport slave (
    input  cfg_load, cfg_interval, cfg_duration, cfg_molenum, hit, hit_index,
    output mole_appear, mole_index, hit_success, miss, hit_count,
           round_busy, round_done
  );

endinterface

// File: rtl/mole_lfsr.sv
// Fibonacci LFSR with synchronous reset to a seed; exposes the low OUT_W
// state bits as the random value.
module mole_lfsr #(
  parameter int                W     = wam_pkg::LFSR_W,
  parameter logic [W-1:0]      TAPS  = wam_pkg::LFSR_TAPS,
  parameter logic [W-1:0]      SEED  = wam_pkg::LFSR_SEED,
  parameter int                OUT_W = W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] rnd
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst)
      q <= SEED;
    else if (en)
      q <= {q[W-2:0], ^(q & TAPS)};
  end

  assign rnd = q[OUT_W-1:0];

endmodule

// File: rtl/mole_scheduler.sv
// Per-round mole sequencer: gap timer, visible-window timer, hit judging and
// round totals. All outputs are registered.
//
//   state | meaning
//   IDLE  | waiting for cfg_load
//   GAP   | counting the interval before the next mole
//   UP    | mole visible, duration counting, hits judged
//   DONE  | single round_done cycle, then IDLE
module mole_scheduler #(
  parameter int                            CNT_W     = wam_pkg::CNT_W,
  parameter int                            IDX_W     = wam_pkg::IDX_W,
  parameter logic [wam_pkg::LFSR_W-1:0]    LFSR_SEED = wam_pkg::LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  mole_scheduler_if.slave   bus
);
  import wam_pkg::*;

  state_e           state_q, state_n;
  logic [CNT_W-1:0] tmr_q, tmr_n;
  logic [CNT_W-1:0] interval_q, interval_n;
  logic [CNT_W-1:0] duration_q, duration_n;
  logic [2:0]       molenum_q, molenum_n;
  logic [2:0]       launched_q, launched_n;
  logic [2:0]       hit_count_q, hit_count_n;
  logic [IDX_W-1:0] index_q, index_n;
  logic             hit_success_q, hit_success_n;
  logic             miss_q, miss_n;
  logic             appear_q, busy_q, done_q;
  logic             mole_end;
  logic [IDX_W-1:0] cand;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  mole_lfsr #(
    .W     (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED),
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .rnd (cand)
  );

  always_comb begin
    state_n       = state_q;
    tmr_n         = tmr_q;
    interval_n    = interval_q;
    duration_n    = duration_q;
    molenum_n     = molenum_q;
    launched_n    = launched_q;
    hit_count_n   = hit_count_q;
    index_n       = index_q;
    hit_success_n = 1'b0;
    miss_n        = 1'b0;
    mole_end      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cfg_load) begin
          interval_n  = bus.cfg_interval;
          duration_n  = bus.cfg_duration;
          molenum_n   = bus.cfg_molenum;
          hit_count_n = '0;
          launched_n  = '0;
          if (bus.cfg_molenum == 3'd0) begin
            state_n = DONE;
          end else begin
            state_n = GAP;
            tmr_n   = at_least_one(bus.cfg_interval);
          end
        end
      end
      GAP: begin
        if (tmr_q == CNT_W'(1)) begin
          state_n    = UP;
          tmr_n      = at_least_one(duration_q);
          // never show the same hole twice in a row
          index_n    = (cand == index_q) ? cand + IDX_W'(1) : cand;
          launched_n = launched_q + 3'd1;
        end else begin
          tmr_n = tmr_q - CNT_W'(1);
        end
      end
      UP: begin
        if (bus.hit && (bus.hit_index == index_q)) begin
          hit_success_n = 1'b1;
          hit_count_n   = hit_count_q + 3'd1;
          mole_end      = 1'b1;
        end else if (tmr_q == CNT_W'(1)) begin
          miss_n   = 1'b1;
          mole_end = 1'b1;
        end else begin
          tmr_n = tmr_q - CNT_W'(1);
        end
        if (mole_end) begin
          if (launched_q == molenum_q) begin
            state_n = DONE;
          end else begin
            state_n = GAP;
            tmr_n   = at_least_one(interval_q);
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // status flags are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      interval_q    <= '0;
      duration_q    <= '0;
      molenum_q     <= '0;
      launched_q    <= '0;
      hit_count_q   <= '0;
      index_q       <= '0;
      hit_success_q <= 1'b0;
      miss_q        <= 1'b0;
      appear_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_n;
      tmr_q         <= tmr_n;
      interval_q    <= interval_n;
      duration_q    <= duration_n;
      molenum_q     <= molenum_n;
      launched_q    <= launched_n;
      hit_count_q   <= hit_count_n;
      index_q       <= index_n;
      hit_success_q <= hit_success_n;
      miss_q        <= miss_n;
      appear_q      <= (state_n == UP);
      busy_q        <= (state_n != IDLE);
      done_q        <= (state_n == DONE);
    end
  end

  assign bus.mole_appear = appear_q;
  assign bus.mole_index  = index_q;
  assign bus.hit_success = hit_success_q;
  assign bus.miss        = miss_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.round_busy  = busy_q;
  assign bus.round_done  = done_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: expected round events are queued when a
// round is launched and matched against what the scheduler produces.
module tb_mole_scheduler;

  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;
  localparam int EV_HIT  = 3;
  localparam int EV_MISS = 4;
  localparam int EV_DONE = 5;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  logic [15:0] mdl_lfsr  = 16'hACE1;
  logic [15:0] lfsr_seen = 16'hACE1;
  logic [3:0]  mdl_idx   = 4'd0;
  logic [3:0]  cand;
  logic [3:0]  exp_idx;
  logic        prev_appear = 1'b0;

  mole_scheduler_if bus ();

  mole_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference LFSR; lfsr_seen holds the value of the cycle that just ended
  always @(posedge clk) begin
    cyc++;
    lfsr_seen = mdl_lfsr;
    if (rst)
      mdl_lfsr = 16'hACE1;
    else
      mdl_lfsr = {mdl_lfsr[14:0], mdl_lfsr[15] ^ mdl_lfsr[13] ^ mdl_lfsr[12] ^ mdl_lfsr[10]};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_val($sformatf("sb_unexpected_ev%0d", kind), kind, 0);
    end else begin
      e = exp_q.pop_front();
      check_val($sformatf("sb_kind_exp%0d", e.kind), kind, e.kind);
      check_val($sformatf("sb_cyc_ev%0d", e.kind), cyc, e.cyc);
      check_val($sformatf("sb_val_ev%0d", e.kind), val, e.val);
    end
  endtask

  // expected event timeline; offs[m] = visible cycle of the correct hit, -1 = none
  task automatic push_round(input int t0, input int ivl, input int dur, input int n,
                            input int offs[8]);
    int iv;
    int dv;
    int t;
    int hits;
    iv   = (ivl == 0) ? 1 : ivl;
    dv   = (dur == 0) ? 1 : dur;
    t    = t0 + 1;
    hits = 0;
    for (int m = 0; m < n; m++) begin
      t += iv;
      push_ev(EV_RISE, t, 0);
      if (offs[m] >= 0) begin
        t = t + offs[m] + 1;
        push_ev(EV_FALL, t, 0);
        push_ev(EV_HIT, t, 0);
        hits++;
      end else begin
        t += dv;
        push_ev(EV_FALL, t, 0);
        push_ev(EV_MISS, t, 0);
      end
    end
    push_ev(EV_DONE, (n == 0) ? t0 + 1 : t, hits);
  endtask

  always @(negedge clk) begin
    if (rst) mdl_idx = 4'd0;
    if (prev_appear && !bus.mole_appear) sb_pop(EV_FALL, 0);
    if (bus.hit_success) sb_pop(EV_HIT, 0);
    if (bus.miss) sb_pop(EV_MISS, 0);
    if (bus.round_done) sb_pop(EV_DONE, int'(bus.hit_count));
    if (!prev_appear && bus.mole_appear) begin
      sb_pop(EV_RISE, 0);
      cand    = lfsr_seen[3:0];
      exp_idx = (cand == mdl_idx) ? cand + 4'd1 : cand;
      check_val("mole_index", 32'(bus.mole_index), 32'(exp_idx));
      check_val("idx_repeat", 32'(bus.mole_index == mdl_idx), 0);
      mdl_idx = exp_idx;
    end
    prev_appear = bus.mole_appear;
  end

  task automatic wait_rise(output bit ok);
    logic last;
    last = bus.mole_appear;
    ok   = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.mole_appear && !last) ok = 1'b1;
      last = bus.mole_appear;
    end
    if (!ok) check_val("timeout_rise", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(posedge clk); #1;
      if (!bus.round_busy) idle = 1'b1;
    end
    if (!idle) check_val("timeout_idle", 0, 1);
  endtask

  task automatic start_round(input int ivl, input int dur, input int n, output int t0);
    bus.cfg_interval = 27'(ivl);
    bus.cfg_duration = 27'(dur);
    bus.cfg_molenum  = 3'(n);
    bus.cfg_load     = 1'b1;
    t0 = cyc;
  endtask

  task automatic run_round(input int ivl, input int dur, input int n, input int offs[8],
                           input bit wrong_first);
    int t0;
    int hits;
    bit ok;
    hits = 0;
    start_round(ivl, dur, n, t0);
    push_round(t0, ivl, dur, n, offs);
    @(posedge clk); #1;
    bus.cfg_load = 1'b0;
    check_val("busy_start", 32'(bus.round_busy), 1);
    for (int m = 0; m < n; m++) begin
      wait_rise(ok);
      if (!ok) return;
      if (offs[m] >= 0) begin
        hits++;
        for (int k = 0; k <= offs[m]; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          bus.hit       = (k == offs[m]) || (wrong_first && m == 0 && k == 0);
          bus.hit_index = (k == offs[m]) ? bus.mole_index : bus.mole_index ^ 4'h5;
        end
        @(posedge clk); #1;
        bus.hit = 1'b0;
      end
    end
    wait_idle();
    check_val("hit_count_hold", 32'(bus.hit_count), 32'(hits));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int none8[8];
    int offs_a[8];
    int offs_b[8];
    int offs_c[8];
    int t0;
    bit ok;

    none8  = '{-1, -1, -1, -1, -1, -1, -1, -1};
    offs_a = '{1, -1, -1, -1, -1, -1, -1, -1};
    offs_b = '{3, -1, -1, -1, -1, -1, -1, -1};
    offs_c = '{0, -1, 1, -1, 0, 1, -1, -1};

    bus.cfg_load     = 1'b0;
    bus.cfg_interval = '0;
    bus.cfg_duration = '0;
    bus.cfg_molenum  = '0;
    bus.hit          = 1'b0;
    bus.hit_index    = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 32'({bus.mole_appear, bus.hit_success, bus.miss, bus.round_busy,
                                    bus.round_done, bus.hit_count, bus.mole_index}), 0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      bus.hit       = 1'($urandom_range(0, 1));
      bus.hit_index = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check_val("idle_quiet", 32'({bus.mole_appear, bus.hit_success, bus.miss, bus.round_busy,
                                   bus.round_done, bus.hit_count, bus.mole_index}), 0);
    end
    bus.hit = 1'b0;

    run_round(5, 4, 2, none8, 1'b0);
    run_round(5, 4, 2, offs_a, 1'b0);
    run_round(5, 4, 2, offs_b, 1'b1);

    // zero-mole round: busy and done for exactly one cycle
    start_round(3, 3, 0, t0);
    push_round(t0, 3, 3, 0, none8);
    @(posedge clk); #1;
    bus.cfg_load = 1'b0;
    check_val("m0_busy", 32'(bus.round_busy), 1);
    check_val("m0_done", 32'(bus.round_done), 1);
    @(posedge clk); #1;
    check_val("m0_busy_after", 32'(bus.round_busy), 0);

    // a second cfg_load during GAP must not disturb the running round
    start_round(2, 3, 1, t0);
    push_round(t0, 2, 3, 1, none8);
    @(posedge clk); #1;
    start_round(9, 9, 0, t0);
    @(posedge clk); #1;
    bus.cfg_load = 1'b0;
    wait_idle();

    run_round(0, 0, 2, none8, 1'b0);

    // reset while a mole is up
    start_round(1, 10, 3, t0);
    push_ev(EV_RISE, t0 + 2, 0);
    @(posedge clk); #1;
    bus.cfg_load = 1'b0;
    wait_rise(ok);
    @(posedge clk); #1;
    rst = 1'b1;
    push_ev(EV_FALL, cyc + 1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst_mid_appear", 32'(bus.mole_appear), 0);
    check_val("rst_mid_busy", 32'(bus.round_busy), 0);
    check_val("rst_mid_index", 32'(bus.mole_index), 0);
    repeat (20) @(posedge clk);
    #1;
    check_val("rst_mid_quiet", 32'({bus.round_busy, bus.miss, bus.round_done}), 0);

    run_round(3, 2, 7, offs_c, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check_val("sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
